// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring.
// Ports: clk, rstn (sync, active-high), start_i/op_i/dividend_i/divisor_i/rd_addr_i
//   request; cancel_i abort; hold_flag_o stall request; ready_o/rd_we_o one-cycle
//   pulse with result_o and rd_addr_o.
module ex_div_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  cancel_i,
    output logic                  hold_flag_o,
    output logic                  ready_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_we_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  sel_rem_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic [DATA_W-1:0]     dvs_q;
    logic [DATA_W-1:0]     rem_q;
    logic [DATA_W-1:0]     quo_q;
    logic [DATA_W-1:0]     result_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [REG_ADDR_W-1:0] rd_out_q;

    logic              accept;
    logic              is_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic              div_zero;
    logic              ovf;
    logic [DATA_W-1:0] spec_res;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    always_comb begin
        accept   = (state == IDLE) && start_i && !cancel_i;
        is_sgn   = !op_i[0];
        a_neg    = is_sgn && dividend_i[DATA_W-1];
        b_neg    = is_sgn && divisor_i[DATA_W-1];
        // |MIN| wraps back to MIN, which is correct read as unsigned
        a_abs    = a_neg ? -dividend_i : dividend_i;
        b_abs    = b_neg ? -divisor_i : divisor_i;
        div_zero = (divisor_i == '0);
        ovf      = is_sgn && (dividend_i == MIN) && (divisor_i == '1);
        if (div_zero)
            spec_res = op_i[1] ? dividend_i : '1;
        else
            spec_res = op_i[1] ? '0 : MIN;
        // one extra bit so the trial subtract sign shows a borrow
        shifted  = {rem_q, quo_q[DATA_W-1]};
        trial    = shifted - {1'b0, dvs_q};
        q_fix    = neg_q_q ? -quo_q : quo_q;
        r_fix    = neg_r_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_rem_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            rd_out_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sel_rem_q <= op_i[1];
                        neg_q_q   <= a_neg ^ b_neg;
                        neg_r_q   <= a_neg;
                        rd_q      <= rd_addr_i;
                        dvs_q     <= b_abs;
                        cnt       <= '0;
                        if (div_zero || ovf) begin
                            result_q <= spec_res;
                            rd_out_q <= rd_addr_i;
                            state    <= DONE;
                        end else begin
                            rem_q <= '0;
                            quo_q <= a_abs;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[DATA_W]) begin
                            rem_q <= trial[DATA_W-1:0];
                            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                        end else begin
                            rem_q <= shifted[DATA_W-1:0];
                            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else begin
                        result_q <= sel_rem_q ? r_fix : q_fix;
                        rd_out_q <= rd_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign hold_flag_o = accept || (state == CALC) || (state == FIX);
    assign ready_o     = (state == DONE);
    assign rd_we_o     = (state == DONE);
    assign result_o    = result_q;
    assign rd_addr_o   = rd_out_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed and random checks of ex_div_unit against an
// arithmetic reference model (results, latency, hold, cancel, reset).
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = '0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        cancel_i = 1'b0;
    logic        hold_flag_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o;

    int checks = 0;
    int errors = 0;

    ex_div_unit #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk),
        .rstn(rstn),
        .start_i(start_i),
        .op_i(op_i),
        .dividend_i(dividend_i),
        .divisor_i(divisor_i),
        .rd_addr_i(rd_addr_i),
        .cancel_i(cancel_i),
        .hold_flag_o(hold_flag_o),
        .ready_o(ready_o),
        .result_o(result_o),
        .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // cycle 0 is the cycle start_i is presented; samples at negedge+1
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        int rdy_c;
        int hc;
        logic [31:0] res;
        logic [4:0] rda;
        logic we;
        logic after;
        rdy_c = -1;
        hc = 0;
        res = '0;
        rda = '0;
        we = 1'b0;
        after = 1'b1;
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        dividend_i = a;
        divisor_i = b;
        rd_addr_i = rd;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start_i = 1'b0;
                op_i = 2'($urandom);
                dividend_i = $urandom;
                divisor_i = $urandom;
                rd_addr_i = 5'($urandom);
                #1;
            end
            if (hold_flag_o === 1'b1) hc++;
            if (rdy_c >= 0 && c == rdy_c + 1) begin
                after = ready_o;
                break;
            end
            if (ready_o === 1'b1 && rdy_c < 0) begin
                rdy_c = c;
                res = result_o;
                rda = rd_addr_o;
                we = rd_we_o;
            end
        end
        chk({tag, "_lat"}, 32'(rdy_c), 32'(ref_lat(op, a, b)));
        chk({tag, "_hold"}, 32'(hc), 32'(ref_lat(op, a, b)));
        chk({tag, "_res"}, res, ref_res(op, a, b));
        chk({tag, "_rd"}, 32'(rda), 32'(rd));
        chk({tag, "_we"}, 32'(we), 32'd1);
        chk({tag, "_pulse"}, 32'(after), 32'd0);
    endtask

    initial begin
        int rcnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] last;

        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_hold", 32'(hold_flag_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_we", 32'(rd_we_o), 32'd0);
        chk("rst_res", result_o, 32'd0);
        chk("rst_rd", 32'(rd_addr_o), 32'd0);

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd8);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd9);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op("divu_min", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("rem_min_3", 2'b10, 32'h8000_0000, 32'd3, 5'd13);

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            run_op($sformatf("rnd%0d", i), 2'($urandom), ra, rb,
                   5'($urandom));
        end

        // cancel in CALC at cycle 10, restart at cycle 12
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b01;
        dividend_i = 32'd1000;
        divisor_i = 32'd3;
        rd_addr_i = 5'd20;
        rcnt = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            cancel_i = (c == 10);
            #1;
            if (ready_o === 1'b1) rcnt++;
            if (c == 10) chk("cancel_hold10", 32'(hold_flag_o), 32'd1);
        end
        chk("cancel_hold11", 32'(hold_flag_o), 32'd0);
        chk("cancel_noready", 32'(rcnt), 32'd0);
        run_op("after_cancel", 2'b01, 32'd1000, 32'd3, 5'd21);

        // cancel wins over a simultaneous start in IDLE
        @(negedge clk);
        start_i = 1'b1;
        cancel_i = 1'b1;
        op_i = 2'b01;
        divisor_i = 32'd0;
        #1;
        chk("idle_cancel_hold", 32'(hold_flag_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0;
        cancel_i = 1'b0;
        #1;
        chk("idle_cancel_ready", 32'(ready_o), 32'd0);

        // reset in the middle of an operation
        last = result_o;
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b01;
        dividend_i = 32'd77;
        divisor_i = 32'd5;
        rd_addr_i = 5'd3;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            rstn = (c == 20);
        end
        #1;
        chk("midrst_hold", 32'(hold_flag_o), 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk("midrst_res", result_o, 32'd0);
        chk("midrst_rd", 32'(rd_addr_o), 32'd0);
        rcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (ready_o === 1'b1) rcnt++;
        end
        chk("midrst_noready", 32'(rcnt), 32'd0);
        chk("midrst_prev_res", last, last);

        // start_i held high across two operations
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b01;
        dividend_i = 32'd100;
        divisor_i = 32'd7;
        rd_addr_i = 5'd4;
        rcnt = 0;
        #1;
        for (int c = 0; c <= 69; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (c <= 68 && ready_o === 1'b1) rcnt++;
            if (c == 34) chk("held_ready34", 32'(ready_o), 32'd1);
            if (c == 34) chk("held_hold34", 32'(hold_flag_o), 32'd0);
            if (c == 35) chk("held_hold35", 32'(hold_flag_o), 32'd1);
            if (c == 69) chk("held_ready69", 32'(ready_o), 32'd1);
            if (c == 69) chk("held_res69", result_o, 32'd14);
        end
        chk("held_pulses", 32'(rcnt), 32'd1);
        start_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage: executes DIV, DIVU, REM and REMU using radix-2 restoring division.
- It is the producer of the EX hold request. hold_flag_o drives the pipeline controller's ex_hold_flag_i, which stalls the earlier stages while a division is in flight.
- The result is returned with a one-cycle ready pulse for writeback.

Parameters:
- DATA_W, 32, operand and result width; all behaviour below is given for 32.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  core clock.
- rstn  input  1  synchronous reset, active-high: rstn==1 at a clk rising edge resets the block.
- start_i  input  1  division request from EX decode; sampled only in IDLE.
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- dividend_i  input  DATA_W  rs1 value; sampled with start_i.
- divisor_i  input  DATA_W  rs2 value; sampled with start_i.
- rd_addr_i  input  REG_ADDR_W  destination register; sampled with start_i.
- cancel_i  input  1  abort the in-flight operation (trap/flush).
- hold_flag_o  output  1  stall request to the pipeline controller.
- ready_o  output  1  one-cycle pulse; result_o, rd_addr_o and rd_we_o are valid.
- result_o  output  DATA_W  quotient or remainder.
- rd_addr_o  output  REG_ADDR_W  destination register for the write.
- rd_we_o  output  1  register write enable; equals ready_o.

Behaviour:
- Reset (rstn==1): state=IDLE, counter=0, all internal registers=0. hold_flag_o, ready_o, rd_we_o=0; result_o=0, rd_addr_o=0. Reset mid-operation discards the operation and produces no ready pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start_i && !cancel_i, latch op_i, rd_addr_i and signs.
  - Form absolute values for signed ops (DIV/REM).
  - If divisor_i==0 or a signed overflow is detected (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF), load the special result and go to DONE.
  - Otherwise load partial remainder=0, quotient register=|dividend|, counter=0, and go to CALC.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1 and trial-subtract |divisor| from rem.
  - If non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - counter increments; after the 32nd iteration (counter==31) go to FIX.
- FIX:
  - Quotient is negated when the signed operand signs differ.
  - Remainder takes the dividend's sign.
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU) into result_o; go to DONE.
- DONE: ready_o=rd_we_o=1 for exactly this cycle with result_o and rd_addr_o stable; next state IDLE. result_o holds its value until the next DONE.
- hold_flag_o (combinational) = (IDLE && start_i && !cancel_i) || CALC || FIX. It is low in DONE, so the stalled instruction retires in the ready cycle.
- Latency, counting the start cycle as cycle 0:
  - Normal: hold high in cycles 0..33 (34 cycles); ready in cycle 34.
  - Special case: hold high in cycle 0 only; ready in cycle 1.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - Overflow: quotient=0x80000000, remainder=0.
- start_i outside IDLE: ignored; it does not restart the operation.
- Back-to-back: start_i may be accepted in the cycle after DONE, not in DONE itself.
- cancel_i:
  - In CALC or FIX: next state IDLE, no ready pulse, hold drops the following cycle.
  - In DONE: ready still pulses. The consumer gates the write.
  - In IDLE: blocks start_i; cancel wins over a simultaneous start.
- Arithmetic: the trial subtract is DATA_W+1 bits wide. Absolute value of 0x80000000 is 0x80000000, treated as unsigned.

Test Plan:
- DIVU 100/7: start at cycle 0 -> hold_flag_o high for cycles 0..33; ready in cycle 34 with result 14 and rd_addr_o = latched rd.
- REM -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFF (-1). DIV of the same operands -> 0xFFFFFFFD (-3).
- Divide by zero, DIV 5/0 -> hold in cycle 0 only; ready in cycle 1; result 0xFFFFFFFF. REMU 5/0 -> result 5.
- Overflow, DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with 1-cycle latency. REM of the same operands -> 0.
- cancel_i asserted at cycle 10 of a DIVU -> IDLE at cycle 11, hold low from cycle 11, no ready pulse. A new start at cycle 12 completes normally.
- Interference cases:
  - rstn=1 at cycle 20 -> all outputs 0 next cycle.
  - start_i held high throughout a DIVU -> only one ready pulse per accepted op; the next op is accepted the cycle after DONE.
